// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one single-port synchronous memory between two requesters.
//            Round-robin by default; define ARB_FIXED_PRIO_EN for fixed
//            priority (requester 0 wins every tie).
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_req,
    input  logic              r0_wr,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    input  logic              r1_req,
    input  logic              r1_wr,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RDRET = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_win;
    logic              r_r0_gnt;
    logic              r_r1_gnt;
    logic              r_r0_rvalid;
    logic              r_r1_rvalid;
    logic              r_mem_en;
    logic              r_mem_wr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_busy;

    logic              w_any_req;
    logic              w_win;
    logic              w_sel_wr;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    assign w_any_req = r0_req | r1_req;

`ifdef ARB_FIXED_PRIO_EN
    assign w_win = ~r0_req;
`else
    // Requester that was not granted last wins a tie.
    logic r_last_gnt;
    assign w_win = (r0_req & r1_req) ? ~r_last_gnt : r1_req;
`endif

    assign w_sel_wr    = w_win ? r1_wr    : r0_wr;
    assign w_sel_addr  = w_win ? r1_addr  : r0_addr;
    assign w_sel_wdata = w_win ? r1_wdata : r0_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_win       <= 1'b0;
            r_r0_gnt    <= 1'b0;
            r_r1_gnt    <= 1'b0;
            r_r0_rvalid <= 1'b0;
            r_r1_rvalid <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            r_last_gnt  <= 1'b1;
`endif
        end else begin
            r_r0_gnt    <= 1'b0;
            r_r1_gnt    <= 1'b0;
            r_r0_rvalid <= 1'b0;
            r_r1_rvalid <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_wr    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        // Command is captured here and held for the ISSUE cycle.
                        r_state     <= S_ISSUE;
                        r_busy      <= 1'b1;
                        r_win       <= w_win;
                        r_r0_gnt    <= ~w_win;
                        r_r1_gnt    <= w_win;
                        r_mem_en    <= 1'b1;
                        r_mem_wr    <= w_sel_wr;
                        r_mem_addr  <= w_sel_addr;
                        r_mem_wdata <= w_sel_wdata;
                    end
                end
                S_ISSUE: begin
`ifndef ARB_FIXED_PRIO_EN
                    r_last_gnt <= r_win;
`endif
                    if (r_mem_wr) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state     <= S_RDRET;
                        r_r0_rvalid <= ~r_win;
                        r_r1_rvalid <= r_win;
                    end
                end
                S_RDRET: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign r0_gnt    = r_r0_gnt;
    assign r1_gnt    = r_r1_gnt;
    assign r0_rvalid = r_r0_rvalid;
    assign r1_rvalid = r_r1_rvalid;
    assign mem_en    = r_mem_en;
    assign mem_wr    = r_mem_wr;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;
    assign rdata     = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed bench for mem_port_arbiter with a transaction-level model
//            and a behavioural single-port memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              r0_req = 1'b0, r0_wr = 1'b0;
    logic [ADDR_W-1:0] r0_addr = '0;
    logic [DATA_W-1:0] r0_wdata = '0;
    logic              r1_req = 1'b0, r1_wr = 1'b0;
    logic [ADDR_W-1:0] r1_addr = '0;
    logic [DATA_W-1:0] r1_wdata = '0;
    logic              r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
    logic [DATA_W-1:0] rdata;
    logic              mem_en, mem_wr, busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_wr(r0_wr), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid),
        .r1_req(r1_req), .r1_wr(r1_wr), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid),
        .rdata(rdata),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural memory; contents reload on reset so the model can track them.
    logic [DATA_W-1:0] mem [8];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) mem[i] <= 8'h37 + 8'(i);
        end else if (mem_en) begin
            if (mem_wr) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    // Transaction model: decides, per sampled request, the cycle each observable
    // event must occur on (grant cycle, read-return cycle, last busy cycle).
    int                cyc = 0;
    int                m_gnt_cyc = -1;
    int                m_rv_cyc = -1;
    int                m_busy_end = -1;
    int                m_win = 0;
    int                m_last = 1;
    logic              m_wr = 1'b0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [DATA_W-1:0] m_wdata = '0;
    logic [DATA_W-1:0] m_rv_data = '0;
    logic [DATA_W-1:0] mm [8];

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            m_gnt_cyc  = -1;
            m_rv_cyc   = -1;
            m_busy_end = -1;
            m_last     = 1;
            for (int i = 0; i < 8; i++) mm[i] = 8'h37 + 8'(i);
        end else if (!((cyc - 1) >= m_gnt_cyc && (cyc - 1) <= m_busy_end)
                     && (r0_req || r1_req)) begin
`ifdef ARB_FIXED_PRIO_EN
            m_win = r0_req ? 0 : 1;
`else
            if (r0_req && r1_req) m_win = (m_last == 0) ? 1 : 0;
            else                  m_win = r0_req ? 0 : 1;
`endif
            m_last    = m_win;
            m_wr      = (m_win == 0) ? r0_wr    : r1_wr;
            m_addr    = (m_win == 0) ? r0_addr  : r1_addr;
            m_wdata   = (m_win == 0) ? r0_wdata : r1_wdata;
            m_gnt_cyc = cyc;
            if (m_wr) begin
                mm[m_addr] = m_wdata;
                m_rv_cyc   = -1;
                m_busy_end = cyc;
            end else begin
                m_rv_data  = mm[m_addr];
                m_rv_cyc   = cyc + 1;
                m_busy_end = cyc + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one cycle, compare every output against the model, then let
    // requesters drop req once granted.
    task automatic step();
        bit e_iss, e_rv;
        @(negedge clk);
        if (chk_en) begin
            e_iss = (cyc == m_gnt_cyc);
            e_rv  = (cyc == m_rv_cyc);
            chk("m_r0_gnt",    32'(r0_gnt),    32'(e_iss && m_win == 0));
            chk("m_r1_gnt",    32'(r1_gnt),    32'(e_iss && m_win == 1));
            chk("m_r0_rvalid", 32'(r0_rvalid), 32'(e_rv && m_win == 0));
            chk("m_r1_rvalid", 32'(r1_rvalid), 32'(e_rv && m_win == 1));
            chk("m_mem_en",    32'(mem_en),    32'(e_iss));
            chk("m_busy",      32'(busy),      32'(cyc >= m_gnt_cyc && cyc <= m_busy_end));
            if (e_iss) begin
                chk("m_mem_wr",    32'(mem_wr),    32'(m_wr));
                chk("m_mem_addr",  32'(mem_addr),  32'(m_addr));
                chk("m_mem_wdata", 32'(mem_wdata), 32'(m_wdata));
            end
            if (e_rv) chk("m_rdata", 32'(rdata), 32'(m_rv_data));
        end
        if (r0_gnt) r0_req = 1'b0;
        if (r1_gnt) r1_req = 1'b0;
    endtask

    task automatic req0(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        r0_req = 1'b1; r0_wr = wr; r0_addr = a; r0_wdata = d;
    endtask

    task automatic req1(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        r1_req = 1'b1; r1_wr = wr; r1_addr = a; r1_wdata = d;
    endtask

    initial begin
        rst = 1'b1;
        step();
        step();
        chk("rst_busy",   32'(busy),      32'd0);
        chk("rst_mem_en", 32'(mem_en),    32'd0);
        chk("rst_gnt",    32'({r0_gnt, r1_gnt}), 32'd0);
        chk("rst_addr",   32'(mem_addr),  32'd0);
        chk("rst_wdata",  32'(mem_wdata), 32'd0);
        chk_en = 1'b1;
        rst    = 1'b0;
        step();

        // r0 write addr 3 = A5
        req0(1'b1, 3'd3, 8'hA5);
        step();
        chk("wr_r0_gnt", 32'(r0_gnt),    32'd1);
        chk("wr_mem_wr", 32'(mem_wr),    32'd1);
        chk("wr_addr",   32'(mem_addr),  32'd3);
        chk("wr_wdata",  32'(mem_wdata), 32'hA5);
        step();

        // r0 read addr 3
        req0(1'b0, 3'd3, 8'h00);
        step();
        chk("rd_r0_gnt", 32'(r0_gnt), 32'd1);
        chk("rd_mem_wr", 32'(mem_wr), 32'd0);
        step();
        chk("rd_r0_rvalid", 32'(r0_rvalid), 32'd1);
        chk("rd_rdata",     32'(rdata),     32'hA5);
        step();

        // Tie after reset; r0 immediately re-requests after its grant
        rst = 1'b1;
        step();
        rst = 1'b0;
        req0(1'b1, 3'd1, 8'h11);
        req1(1'b1, 3'd2, 8'h22);
        step();
        chk("tie1_r0_gnt", 32'(r0_gnt), 32'd1);
        chk("tie1_r1_gnt", 32'(r1_gnt), 32'd0);
        req0(1'b1, 3'd4, 8'h44);
        step();
        chk("tie_idle_gnt", 32'({r0_gnt, r1_gnt}), 32'd0);
        step();
`ifdef ARB_FIXED_PRIO_EN
        chk("tie2_r0_gnt", 32'(r0_gnt), 32'd1);
`else
        chk("tie2_r1_gnt", 32'(r1_gnt), 32'd1);
`endif
        step();
        step();
`ifdef ARB_FIXED_PRIO_EN
        chk("tie3_r1_gnt", 32'(r1_gnt), 32'd1);
`else
        chk("tie3_r0_gnt", 32'(r0_gnt), 32'd1);
`endif
        step();

        // r1 read addr 5 (initial content 3C)
        req1(1'b0, 3'd5, 8'h00);
        step();
        chk("r1rd_gnt", 32'(r1_gnt), 32'd1);
        step();
        chk("r1rd_rvalid",    32'(r1_rvalid), 32'd1);
        chk("r1rd_rdata",     32'(rdata),     32'h3C);
        chk("r1rd_r0_rvalid", 32'(r0_rvalid), 32'd0);
        step();

        // r1 raises req while r0 is in ISSUE
        req0(1'b1, 3'd6, 8'h66);
        step();
        req1(1'b1, 3'd7, 8'h77);
        step();
        chk("late_r1_no_gnt", 32'(r1_gnt), 32'd0);
        step();
        chk("late_r1_gnt",  32'(r1_gnt),   32'd1);
        chk("late_r1_addr", 32'(mem_addr), 32'd7);
        step();

        // Read back a value written earlier
        req0(1'b0, 3'd4, 8'h00);
        step();
        step();
        chk("rb_rdata", 32'(rdata), 32'h44);
        step();

        // Reset while a read is in ISSUE drops the return
        req0(1'b0, 3'd3, 8'h00);
        step();
        rst = 1'b1;
        step();
        chk("abort_rvalid", 32'(r0_rvalid), 32'd0);
        chk("abort_busy",   32'(busy),      32'd0);
        rst = 1'b0;
        step();
        chk("abort_rvalid2", 32'(r0_rvalid), 32'd0);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
